// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multicycle instruction sequencer between the instruction source,
// the register file and the ALU.
// Build option: define CTRL_SATURATE_EN to clamp the write data on signed overflow;
// without it the ALU result is written back as-is (wrap).
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | ready for an instruction, read addresses driven on transfer
// S_DECODE    | register file read in flight
// S_EXECUTE   | alu_start high, operands captured on exit
// S_WAIT_ALU  | waiting for alu_done, watchdog counting
// S_WRITEBACK | retire pulse, optional write strobe, flags updated
module ctrl_sequencer #(
   parameter int DW          = 16,
   parameter int AW          = 4,
   parameter int OP_W        = 7,
   parameter int ALU_OP_W    = 4,
   parameter int ALU_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [OP_W-1:0]     op_code,
   input  logic [AW-1:0]       regsrc1,
   input  logic [AW-1:0]       regsrc2,
   input  logic [AW-1:0]       regdes,
   output logic [AW-1:0]       rd_addr1,
   output logic [AW-1:0]       rd_addr2,
   input  logic [DW-1:0]       rd_data1,
   input  logic [DW-1:0]       rd_data2,
   output logic [DW-1:0]       alu_a,
   output logic [DW-1:0]       alu_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_start,
   input  logic                alu_done,
   input  logic [DW-1:0]       alu_y,
   input  logic                alu_carry,
   input  logic                alu_signov,
   output logic                wr_en,
   output logic [AW-1:0]       wr_addr,
   output logic [DW-1:0]       wr_data,
   output logic                carry_flag,
   output logic                overflow_flag,
   output logic                timeout_err,
   output logic                busy,
   output logic                retire
);

   // Watchdog counts 0..ALU_TIMEOUT-1; with the watchdog disabled it just wraps.
   localparam int WD_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(ALU_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXECUTE,
      S_WAIT_ALU,
      S_WRITEBACK
   } state_t;

   state_t          state;
   logic [OP_W-1:0] op_q;
   logic [AW-1:0]   dest_q;
   logic [WD_W-1:0] wd_cnt;
   logic [DW-1:0]   wb_data;

`ifdef CTRL_SATURATE_EN
   // Clamp toward the sign of operand A when the ALU reports signed overflow.
   always_comb begin
      wb_data = alu_y;
      if (alu_signov) begin
         wb_data = alu_a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
   end
`else
   assign wb_data = alu_y;
`endif

   // Sequencer FSM; every output is a register updated on the state transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         op_q          <= '0;
         dest_q        <= '0;
         wd_cnt        <= '0;
         instr_ready   <= 1'b1;
         busy          <= 1'b0;
         rd_addr1      <= '0;
         rd_addr2      <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= '0;
         alu_start     <= 1'b0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         carry_flag    <= 1'b0;
         overflow_flag <= 1'b0;
         timeout_err   <= 1'b0;
         retire        <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         wr_en     <= 1'b0;
         retire    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op_q        <= op_code;
                  dest_q      <= regdes;
                  rd_addr1    <= regsrc1;
                  rd_addr2    <= regsrc2;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               alu_start <= 1'b1;
               state     <= S_EXECUTE;
            end
            S_EXECUTE: begin
               alu_a  <= rd_data1;
               alu_b  <= rd_data2;
               alu_op <= op_q[ALU_OP_W-1:0];
               wd_cnt <= '0;
               state  <= S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
               if (alu_done) begin
                  retire        <= 1'b1;
                  carry_flag    <= alu_carry;
                  overflow_flag <= alu_signov;
                  if (!op_q[OP_W-1]) begin
                     wr_en   <= 1'b1;
                     wr_addr <= dest_q;
                     wr_data <= wb_data;
                  end
                  state <= S_WRITEBACK;
               end else if ((ALU_TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
                  timeout_err <= 1'b1;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            S_WRITEBACK: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule
